// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller.
//   state_e      : controller state encoding (IDLE, SHIFT, PARITY, DONE)
//   DefaultDataW : default frame payload width
//   cnt_width()  : bit-counter width able to hold the value DATA_W
package sipo_ctrl_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2,
    StDone   = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Generic left-shifting serial-in/parallel-out register.
//   clk       : system clock
//   rst       : asynchronous active-low reset, clears q
//   shift_en  : shift serial_in into the LSB this cycle
//   serial_in : serial data bit
//   q         : register contents, first-shifted bit ends up in the MSB
module sipo_shift_core
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[DATA_W-2:0], serial_in};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller sequencing a SIPO shifter into a one-entry valid/ready buffer.
// Optional build macro: SIPO_PARITY_CHECK_EN adds a trailing even-parity bit per
// frame and the parity_err output.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : arms a capture (ignored while busy)
//   abort               : drop the frame in progress, highest priority
//   bit_en, serial_in   : qualified serial bit strobe and data
//   frame_data/valid    : captured word (first bit in MSB) and its valid flag
//   frame_ready         : consumer accepts on frame_valid & frame_ready
//   busy                : controller is not idle
//   overrun, clr_overrun: sticky dropped-frame flag and its clear
//   parity_err          : (macro only) parity result held alongside frame_data
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy,
  output logic              overrun,
`ifdef SIPO_PARITY_CHECK_EN
  output logic              parity_err,
`endif
  input  logic              clr_overrun
);

  localparam int unsigned CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              overrun_q;
  logic              shift_en;
  logic              buf_load;
  logic              buf_drop;
  logic              buf_take;

`ifdef SIPO_PARITY_CHECK_EN
  logic par_err_q;     // parity result of the frame awaiting DONE
  logic parity_err_q;  // buffered copy, travels with data_q
`endif

  sipo_shift_core #(
    .DATA_W (DATA_W)
  ) u_shift_core (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .q         (shreg)
  );

  always_comb begin
    shift_en = (state_q == StShift) && bit_en && !abort;
    // Abort suppresses the DONE transfer; a consumer handshake still completes.
    buf_load = (state_q == StDone) && !abort && (!valid_q || frame_ready);
    buf_drop = (state_q == StDone) && !abort && valid_q && !frame_ready;
    buf_take = valid_q && frame_ready;
  end

  // Controller FSM and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
`ifdef SIPO_PARITY_CHECK_EN
      par_err_q <= 1'b0;
`endif
    end else if (abort) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StShift;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          if (bit_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LastCnt) begin
`ifdef SIPO_PARITY_CHECK_EN
              state_q <= StParity;
`else
              state_q <= StDone;
`endif
            end
          end
        end
        StParity: begin
`ifdef SIPO_PARITY_CHECK_EN
          if (bit_en) begin
            // Even parity: data bits XOR parity bit must be zero.
            par_err_q <= ^shreg ^ serial_in;
            state_q   <= StDone;
          end
`else
          state_q <= StIdle;
`endif
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // One-entry output buffer and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (buf_load) begin
        data_q       <= shreg;
        valid_q      <= 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
        parity_err_q <= par_err_q;
`endif
      end else if (buf_take) begin
        valid_q <= 1'b0;
      end

      // A fresh overrun wins over a simultaneous clear.
      if (buf_drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;
`ifdef SIPO_PARITY_CHECK_EN
  assign parity_err  = parity_err_q;
`endif

endmodule
